bus_arbiter: RTL
================

# bus_arbiter

Sequencer and arbiter for the shared 8-bit data bus of the nic8 board. Up to four requesters (for example PC, ALU result, RAM and input port) each sit behind an LS245 transceiver, and the destination registers are LS273s. The block grants the bus to one requester at a time in round-robin order. For each transfer it enables that requester's transceiver, waits a settle time, strobes the selected destination register's clock, and then acknowledges the requester.

## Interface
Parameters:
- SETTLE, default 1: cycles the bus is driven before the load strobe. Legal range 1..15.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- CLRB  in  1  reset, asynchronous, active-low.
- REQ  in  4  REQ[i]=1 means requester i wants one bus transfer.
- DST  in  12  destination register index per requester. DST[3i+2:3i] belongs to requester i.
- GNT  out  4  one-hot grant. All zero when idle.
- DRVB  out  4  active-low transceiver enable. DRVB[i] drives the ENB pin of requester i's LS245.
- LDB  out  8  active-low load strobes, one per destination register. Its rising edge clocks the LS273.
- ACK  out  1×4  one-cycle done pulse per requester.
- BUSY  out  1  high whenever the state is not IDLE.

## Operation
- The state machine has four states: IDLE, DRIVE, LOAD, DONE. The block also holds:
  - a 2-bit last-winner pointer LAST;
  - a 2-bit winner register W;
  - a 3-bit destination register D;
  - a 4-bit settle counter.
- **IDLE**
  - If REQ is nonzero, choose the winner as the first requester with REQ set, searching from (LAST+1) mod 4 upward with wrap-around.
  - Capture the winner in W and its DST field in D, load the settle counter with SETTLE, and go to DRIVE.
  - If REQ is zero, stay in IDLE.
- **DRIVE**
  - GNT[W]=1 and DRVB[W]=0.
  - The counter decrements each cycle. When it reaches 1, go to LOAD.
  - The block stays in DRIVE for exactly SETTLE cycles.
- **LOAD**
  - GNT[W]=1, DRVB[W]=0 and LDB[D]=0, for exactly one cycle.
  - Then go to DONE. LDB[D] rises at the DONE entry edge while the bus is still valid.
- **DONE**
  - ACK[W]=1, GNT=0 and DRVB=4'hF.
  - LAST is set to W, and the next state is IDLE.
  - The extra IDLE cycle is required as a bus turnaround, so no two transceivers ever overlap.
- A transfer is committed once granted. Dropping REQ[W] mid-transfer does not abort it.
- A requester must drop REQ in the cycle it sees ACK. If REQ is still high in the following IDLE cycle, it competes again as a new request.
- REQ and DST are sampled only in IDLE. Changes to them during DRIVE, LOAD or DONE have no effect.
- At most one bit of GNT, one bit of ~DRVB, one bit of ~LDB and one bit of ACK is active at any time.
- All outputs are registered (glitch-free), because LDB drives register clocks directly.

## Timing
- Reset (CLRB=0) acts immediately without a clock and gives:
  - state IDLE, LAST=3 (so requester 0 wins first), W=0, D=0, counter=0;
  - GNT=0, DRVB=4'hF, LDB=8'hFF, ACK=0, BUSY=0.
- Asserting reset mid-transfer releases DRVB and LDB asynchronously. A truncated LDB rising edge is acceptable; the destination contents are undefined after that.
- Cycle numbering starts at 0, the IDLE cycle in which REQ is sampled:
  - cycles 1..SETTLE are DRIVE;
  - cycle SETTLE+1 is LOAD;
  - cycle SETTLE+2 is DONE (ACK high);
  - cycle SETTLE+3 is IDLE.
- Throughput is one transfer per SETTLE+3 cycles under continuous requests.
- BUSY=1 from cycle 1 through cycle SETTLE+2 inclusive.
- Fairness: with all four requests held high, the grant order is 0,1,2,3,0,… and no requester waits more than three transfers.

## Test plan
- **Reset:** pulse CLRB low with CLK stopped, in mid-LOAD. Outputs must go to GNT=0, DRVB=1111, LDB=FF, ACK=0, BUSY=0 with no clock edge. After release, REQ=1111 grants requester 0 first.
- **Single transfer:** SETTLE=1, REQ=0010, DST for requester 1 = 5. Required response:
  - cycle 1: GNT=0010, DRVB=1101;
  - cycle 2: LDB=11011111;
  - cycle 3: ACK=0010, DRVB=1111;
  - cycle 4: BUSY=0.
- **Round-robin:** REQ=1111 held throughout, 8 transfers. ACK sequence must be 0,1,2,3,0,1,2,3, with exactly one idle cycle between DONE and the next DRIVE.
- **Skip and wrap:** with LAST=2, REQ=1001. Requester 3 wins; on the next round requester 0 wins.
- **Commitment and late changes:** drop REQ and change DST during DRIVE. LOAD must still strobe the originally captured destination, and ACK must still pulse.
- **Settle length:** SETTLE=3, REQ=0100, DST for requester 2 = 0. Required response:
  - DRVB=1011 in cycles 1..3;
  - LDB=11111110 in cycle 4;
  - ACK in cycle 5.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin sequencer for the shared 8-bit nic8 data bus: grants one
// requester at a time, drives its LS245, strobes one LS273 and acknowledges.
module bus_arbiter #(
    parameter int SETTLE = 1
) (
    input  logic        CLK,
    input  logic        CLRB,
    input  logic [3:0]  REQ,
    input  logic [11:0] DST,
    output logic [3:0]  GNT,
    output logic [3:0]  DRVB,
    output logic [7:0]  LDB,
    output logic [3:0]  ACK,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  last, last_nx;
    logic [1:0]  w, w_nx;
    logic [2:0]  d, d_nx;
    logic [3:0]  cnt, cnt_nx;

    logic [1:0]  pick;
    logic [1:0]  idx;
    logic        found;

    logic [3:0]  gnt_nx;
    logic [3:0]  drvb_nx;
    logic [7:0]  ldb_nx;
    logic [3:0]  ack_nx;
    logic        busy_nx;

    // Search starts just after the previous winner; k=4 wraps back to LAST itself.
    always_comb begin
        pick  = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && REQ[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        w_nx     = w;
        d_nx     = d;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    w_nx     = pick;
                    d_nx     = DST[3*pick +: 3];
                    cnt_nx   = 4'(SETTLE);
                    state_nx = DRIVE;
                end
            end
            DRIVE: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                state_nx = DONE;
            end
            DONE: begin
                last_nx  = w;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state and registered, because LDB
    // clocks the destination registers directly and must never glitch.
    always_comb begin
        gnt_nx  = 4'h0;
        drvb_nx = 4'hF;
        ldb_nx  = 8'hFF;
        ack_nx  = 4'h0;
        busy_nx = (state_nx != IDLE);
        case (state_nx)
            DRIVE: begin
                gnt_nx[w_nx]  = 1'b1;
                drvb_nx[w_nx] = 1'b0;
            end
            LOAD: begin
                gnt_nx[w_nx]  = 1'b1;
                drvb_nx[w_nx] = 1'b0;
                ldb_nx[d_nx]  = 1'b0;
            end
            DONE: begin
                ack_nx[w_nx] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLRB) begin
        if (!CLRB) begin
            state <= IDLE;
            last  <= 2'd3;
            w     <= 2'd0;
            d     <= 3'd0;
            cnt   <= 4'd0;
            GNT   <= 4'h0;
            DRVB  <= 4'hF;
            LDB   <= 8'hFF;
            ACK   <= 4'h0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            w     <= w_nx;
            d     <= d_nx;
            cnt   <= cnt_nx;
            GNT   <= gnt_nx;
            DRVB  <= drvb_nx;
            LDB   <= ldb_nx;
            ACK   <= ack_nx;
            BUSY  <= busy_nx;
        end
    end

endmodule
